// File: rtl/clock_set_ctrl.sv
// Mode/adjust scheduler for the digital clock: routes tick/carry pulses in RUN and
// turns push-button edges and auto-repeat into add/sub pulses for the selected field.
module clock_set_ctrl #(
  parameter int unsigned REPEAT_DELAY = 50,
  parameter int unsigned REPEAT_RATE  = 10,
  parameter int unsigned IDLE_TIMEOUT = 1000,
  parameter int unsigned CNT_W        = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       sec_tick,
  input  logic       s_cout,
  input  logic       m_cout,
  output logic       s_add,
  output logic       s_sub,
  output logic       m_add,
  output logic       m_sub,
  output logic       h_add,
  output logic       h_sub,
  output logic [2:0] field_sel,
  output logic       setting,
  output logic       blink
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_S = 2'd1, SET_M = 2'd2, SET_H = 2'd3} mode_t;

  localparam logic [CNT_W-1:0] DELAY_C   = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RELOAD_C  = CNT_W'(REPEAT_DELAY - REPEAT_RATE + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(IDLE_TIMEOUT - 1);

  mode_t            state, state_nx;
  logic [2:0]       mode_sr, up_sr, dn_sr;
  logic [CNT_W-1:0] hold_cnt, hold_nx, idle_cnt, idle_nx;
  logic             mode_edge, up_edge, dn_edge, any_edge;
  logic             up_only, dn_only, rep_fire, up_pulse, dn_pulse;
  logic [5:0]       adj_nx;
  logic [2:0]       field_nx;
  logic             setting_nx, blink_nx;

  // Two synchroniser flops ([0],[1]) plus one delay flop ([2]) for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sr <= '0;
      up_sr   <= '0;
      dn_sr   <= '0;
    end else begin
      mode_sr <= {mode_sr[1:0], btn_mode};
      up_sr   <= {up_sr[1:0], btn_up};
      dn_sr   <= {dn_sr[1:0], btn_down};
    end
  end

  assign mode_edge = mode_sr[1] & ~mode_sr[2];
  assign up_edge   = up_sr[1] & ~up_sr[2];
  assign dn_edge   = dn_sr[1] & ~dn_sr[2];
  assign any_edge  = mode_edge | up_edge | dn_edge;
  assign up_only   = up_sr[1] & ~dn_sr[1];
  assign dn_only   = dn_sr[1] & ~up_sr[1];

  // Next state, counters and output values
  always_comb begin
    state_nx = state;
    idle_nx  = '0;
    hold_nx  = '0;
    rep_fire = 1'b0;
    adj_nx   = '0;
    field_nx = 3'b000;

    if (mode_edge) begin
      case (state)
        RUN:     state_nx = SET_S;
        SET_S:   state_nx = SET_M;
        SET_M:   state_nx = SET_H;
        default: state_nx = RUN;
      endcase
    end else if (state != RUN && !any_edge && idle_cnt == TIMEOUT_C) begin
      state_nx = RUN;
    end

    if (state_nx == state && !any_edge && state != RUN)
      idle_nx = idle_cnt + CNT_W'(1);

    // Hold counter tracks how long a single direction has been held
    if (mode_edge || !(up_only || dn_only)) begin
      hold_nx = '0;
    end else if (up_edge || dn_edge) begin
      hold_nx = CNT_W'(1);
    end else if (hold_cnt == DELAY_C) begin
      rep_fire = 1'b1;
      hold_nx  = RELOAD_C;
    end else begin
      hold_nx = hold_cnt + CNT_W'(1);
    end

    up_pulse = up_only & ~mode_edge & (up_edge | rep_fire);
    dn_pulse = dn_only & ~mode_edge & (dn_edge | rep_fire);

    case (state)
      RUN:     adj_nx      = {sec_tick, 1'b0, s_cout, 1'b0, m_cout, 1'b0};
      SET_S:   adj_nx[5:4] = {up_pulse, dn_pulse};
      SET_M:   adj_nx[3:2] = {up_pulse, dn_pulse};
      default: adj_nx[1:0] = {up_pulse, dn_pulse};
    endcase

    case (state_nx)
      SET_S:   field_nx = 3'b001;
      SET_M:   field_nx = 3'b010;
      SET_H:   field_nx = 3'b100;
      default: field_nx = 3'b000;
    endcase

    setting_nx = (state_nx != RUN);
    blink_nx   = (state_nx != state) ? 1'b0 : (blink ^ sec_tick);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      hold_cnt  <= '0;
      idle_cnt  <= '0;
      {s_add, s_sub, m_add, m_sub, h_add, h_sub} <= '0;
      field_sel <= 3'b000;
      setting   <= 1'b0;
      blink     <= 1'b0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_nx;
      idle_cnt  <= idle_nx;
      {s_add, s_sub, m_add, m_sub, h_add, h_sub} <= adj_nx;
      field_sel <= field_nx;
      setting   <= setting_nx;
      blink     <= blink_nx;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: table vectors, directed corner sequences
// and randomized stimulus against a cycle-level behavioural model.
module tb_clock_set_ctrl;

  localparam int unsigned RD = 50;
  localparam int unsigned RR = 10;
  localparam int unsigned IT = 1000;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_mode, btn_up, btn_down, sec_tick, s_cout, m_cout;
  logic s_add, s_sub, m_add, m_sub, h_add, h_sub;
  logic [2:0] field_sel;
  logic setting, blink;
  logic [10:0] dut_out;

  always #5 clk = ~clk;

  clock_set_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR), .IDLE_TIMEOUT(IT), .CNT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .sec_tick(sec_tick), .s_cout(s_cout), .m_cout(m_cout),
    .s_add(s_add), .s_sub(s_sub), .m_add(m_add), .m_sub(m_sub), .h_add(h_add), .h_sub(h_sub),
    .field_sel(field_sel), .setting(setting), .blink(blink)
  );

  assign dut_out = {s_add, s_sub, m_add, m_sub, h_add, h_sub, field_sel, setting, blink};

  int total = 0;
  int bad   = 0;

  // Behavioural model state: raw button history, mode number, idle/hold lengths
  logic [2:0]  qm, qu, qd;
  int          mmode, midle, mlen;
  bit          mclr, mblink;
  logic [10:0] exp_out;

  task automatic check_vec(input string name, input logic [10:0] got, input logic [10:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    qm = '0; qu = '0; qd = '0;
    mmode = 0; midle = 0; mlen = 0; mclr = 1'b1; mblink = 1'b0;
    exp_out = '0;
  endtask

  task automatic model_step(input logic bm, input logic bu, input logic bd,
                            input logic st, input logic sc, input logic mc);
    logic me, ue, de, uo, dno, anye, rep, upp, dnp;
    int len, nm;
    logic [5:0] adj;
    logic [2:0] fld;
    me   = qm[1] & ~qm[2];
    ue   = qu[1] & ~qu[2];
    de   = qd[1] & ~qd[2];
    uo   = qu[1] & ~qd[1];
    dno  = qd[1] & ~qu[1];
    anye = me | ue | de;
    len  = (mclr || ue || de) ? 0 : mlen + 1;
    rep  = (uo || dno) && len >= int'(RD) && ((len - int'(RD)) % int'(RR)) == 0;
    upp  = uo && !me && (ue || rep);
    dnp  = dno && !me && (de || rep);
    mclr = me || !(uo || dno);
    mlen = len;
    nm = mmode;
    if (me) nm = (mmode + 1) % 4;
    else if (mmode != 0 && !anye && midle == int'(IT) - 1) nm = 0;
    if (nm != mmode || anye || mmode == 0) midle = 0;
    else midle++;
    adj = '0;
    case (mmode)
      0:       adj = {st, 1'b0, sc, 1'b0, mc, 1'b0};
      1:       adj[5:4] = {upp, dnp};
      2:       adj[3:2] = {upp, dnp};
      default: adj[1:0] = {upp, dnp};
    endcase
    mblink = (nm != mmode) ? 1'b0 : (mblink ^ st);
    fld = (nm == 0) ? 3'b000 : 3'(1 << (nm - 1));
    mmode = nm;
    exp_out = {adj, fld, (nm != 0), mblink};
    qm = {qm[1:0], bm};
    qu = {qu[1:0], bu};
    qd = {qd[1:0], bd};
  endtask

  task automatic step();
    @(posedge clk);
    model_step(btn_mode, btn_up, btn_down, sec_tick, s_cout, m_cout);
    #1;
    check_vec("model", dut_out, exp_out);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    step(); step();
    btn_mode = 1'b0;
    repeat (4) step();
  endtask

  typedef struct { logic st; logic sc; logic mc; logic [2:0] exp_add; } run_vec_t;
  typedef struct { logic [2:0] exp_field; logic exp_setting; } mode_vec_t;

  initial begin
    #1ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    run_vec_t  rv[5];
    mode_vec_t mv[4];
    int cnt, first, last, found;
    bit saw;
    int pm, pu, pd;

    rv[0] = '{1'b1, 1'b0, 1'b0, 3'b100};
    rv[1] = '{1'b0, 1'b1, 1'b0, 3'b010};
    rv[2] = '{1'b0, 1'b0, 1'b1, 3'b001};
    rv[3] = '{1'b1, 1'b1, 1'b1, 3'b111};
    rv[4] = '{1'b0, 1'b0, 1'b0, 3'b000};
    mv[0] = '{3'b001, 1'b1};
    mv[1] = '{3'b010, 1'b1};
    mv[2] = '{3'b100, 1'b1};
    mv[3] = '{3'b000, 1'b0};

    rst_n = 1'b0;
    {btn_mode, btn_up, btn_down, sec_tick, s_cout, m_cout} = '0;
    model_reset();
    #23;
    check_vec("reset", dut_out, 11'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // RUN routing vector table
    for (int i = 0; i < 5; i++) begin
      {sec_tick, s_cout, m_cout} = {rv[i].st, rv[i].sc, rv[i].mc};
      step();
      check_vec("run_tbl", {8'd0, s_add, m_add, h_add}, {8'd0, rv[i].exp_add});
    end
    {sec_tick, s_cout, m_cout} = '0;

    // Carry routing at cycles 10/20/30 appears at 11/21/31
    for (int c = 0; c < 40; c++) begin
      sec_tick = (c == 10); s_cout = (c == 20); m_cout = (c == 30);
      step();
      check_vec("run_route", {5'd0, s_add, s_sub, m_add, m_sub, h_add, h_sub},
                {5'd0, (c == 10), 1'b0, (c == 20), 1'b0, (c == 30), 1'b0});
    end
    {sec_tick, s_cout, m_cout} = '0;

    // Mode cycling; a tick before each press makes the blink clear observable
    for (int i = 0; i < 4; i++) begin
      sec_tick = 1'b1; step(); sec_tick = 1'b0; step();
      press_mode();
      check_vec("mode_tbl", {6'd0, field_sel, setting, blink},
                {6'd0, mv[i].exp_field, mv[i].exp_setting, 1'b0});
    end

    // Single adjust in SET_M, with a tick that must not reach s_add
    press_mode(); press_mode();
    cnt = 0; first = -1; saw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      btn_up = (c < 3); sec_tick = (c == 6);
      step();
      if (m_add) begin cnt++; if (first < 0) first = c; end
      if (s_add) saw = 1'b1;
    end
    {btn_up, sec_tick} = '0;
    check_int("single_cnt", cnt, 1);
    check_int("single_lat", first, 2);
    check_int("frozen_s_add", int'(saw), 0);

    // Auto-repeat in SET_H: held 100 cycles -> edge + 5 repeats
    press_mode();
    cnt = 0; last = -1;
    for (int c = 0; c < 130; c++) begin
      btn_down = (c < 100);
      step();
      if (h_sub) begin cnt++; last = c; end
    end
    check_int("repeat_cnt", cnt, 6);
    check_int("repeat_last", last, 92);

    // Up and down together: no pulses
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      btn_up = (c < 8); btn_down = (c < 8);
      step();
      if ({s_add, s_sub, m_add, m_sub, h_add, h_sub} != 6'd0) cnt++;
    end
    check_int("both_pressed", cnt, 0);

    // Mode and up in the same cycle from SET_S: advance, no add
    press_mode(); press_mode();
    cnt = 0;
    for (int c = 0; c < 13; c++) begin
      btn_mode = (c < 3); btn_up = (c < 3);
      step();
      if (s_add | m_add) cnt++;
    end
    check_int("mode_up_cnt", cnt, 0);
    check_vec("mode_up_state", {7'd0, field_sel, setting}, {7'd0, 3'b010, 1'b1});

    // Idle timeout: SET_M -> SET_H -> RUN -> SET_S, then stay idle
    press_mode(); press_mode(); press_mode();
    for (int c = 0; c < 1010; c++) begin
      step();
      if (c == 980) check_vec("idle_still_set", {10'd0, setting}, {10'd0, 1'b1});
    end
    check_vec("idle_timeout", {7'd0, field_sel, setting}, 11'd0);

    // Async reset while a repeat pulse is high
    press_mode(); press_mode(); press_mode();
    found = 0;
    btn_down = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (c > 10 && h_sub === 1'b1) begin found = 1; break; end
    end
    check_int("rpt_found", found, 1);
    #2 rst_n = 1'b0;
    #1 check_vec("rst_async", dut_out, 11'd0);
    btn_down = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized stimulus in epochs of differing button activity
    for (int e = 0; e < 15; e++) begin
      pm = (e % 3 == 0) ? 20 : 400;
      pu = (e % 2 == 1) ? 8 : 120;
      pd = (e % 4 == 2) ? 10 : 150;
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, pm - 1) == 0) btn_mode = ~btn_mode;
        if ($urandom_range(0, pu - 1) == 0) btn_up = ~btn_up;
        if ($urandom_range(0, pd - 1) == 0) btn_down = ~btn_down;
        sec_tick = ($urandom_range(0, 7) == 0);
        s_cout   = ($urandom_range(0, 19) == 0);
        m_cout   = ($urandom_range(0, 29) == 0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
